// File: rtl/fsm_pkg.sv
// Shared scheduler types: state encoding and default floor count.
package fsm_pkg;

  localparam int unsigned NFLOORS_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_WAIT = 2'd2,
    S_DOOR = 2'd3
  } sched_state_t;

endpackage

// File: rtl/elevator_sched_door_timer.sv
// Door dwell countdown: loads on DOOR entry, expires on the last open cycle.
module door_timer #(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(CYCLES);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // A count of one means this is the final cycle the door is open.
  assign expire_c = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elevator_sched.sv
// SCAN elevator scheduler: latches floor calls and issues move/door commands
// to the elevator FSM, with a sticky fault if a commanded move never arrives.
module elevator_sched
  import fsm_pkg::*;
#(
  parameter int unsigned NFLOORS        = NFLOORS_DEFAULT,
  parameter int unsigned DOOR_CYCLES    = 8,
  parameter int unsigned ARRIVE_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NFLOORS-1:0]         call,
  input  logic [$clog2(NFLOORS)-1:0] floor,
  output logic                       up,
  output logic                       down,
  output logic                       door_open,
  output logic [NFLOORS-1:0]         pending,
  output logic                       dir,
  output logic                       fault
);

  localparam int unsigned FW = $clog2(NFLOORS);
  localparam int unsigned WW = $clog2(ARRIVE_TIMEOUT + 1);

  sched_state_t      state_q, state_d;
  logic [NFLOORS-1:0] pending_q, pending_d;
  logic              dir_q, dir_d;
  logic              fault_q, fault_d;
  logic              up_q, up_d;
  logic              down_q, down_d;
  logic              door_q, door_d;
  logic [FW-1:0]     start_floor_q, start_floor_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;

  logic [NFLOORS-1:0] above_mask, below_mask, here_mask;
  logic req_here_c, req_above_c, req_below_c, req_fwd_c, req_back_c;
  logic door_load_c, door_expire_c;

  // Floor-relative thermometer masks over the latched requests.
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    here_mask  = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      above_mask[i] = (FW'(i) > floor);
      below_mask[i] = (FW'(i) < floor);
      here_mask[i]  = (FW'(i) == floor);
    end
  end

  assign req_here_c  = |(pending_q & here_mask);
  assign req_above_c = (|(pending_q & above_mask)) && (floor != FW'(NFLOORS - 1));
  assign req_below_c = (|(pending_q & below_mask)) && (floor != '0);
  assign req_fwd_c   = dir_q ? req_below_c : req_above_c;
  assign req_back_c  = dir_q ? req_above_c : req_below_c;

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    fault_d       = fault_q;
    start_floor_d = start_floor_q;
    wait_cnt_d    = wait_cnt_q;
    pending_d     = (pending_q | call) & ~((state_q == S_DOOR) ? here_mask : '0);

    case (state_q)
      S_IDLE: begin
        if (req_here_c) begin
          state_d = S_DOOR;
        end else if (!fault_q) begin
          if (req_above_c && (!dir_q || !req_below_c)) begin
            dir_d   = 1'b0;
            state_d = S_MOVE;
          end else if (req_below_c) begin
            dir_d   = 1'b1;
            state_d = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        start_floor_d = floor;
        wait_cnt_d    = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (floor != start_floor_q) begin
          if (req_here_c) begin
            state_d = S_DOOR;
          end else if (req_fwd_c) begin
            state_d = S_MOVE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_cnt_q == WW'(ARRIVE_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_DOOR: begin
        // A faulted car may still cycle its door but never departs.
        if (door_expire_c) begin
          if (fault_q) begin
            state_d = S_IDLE;
          end else if (req_fwd_c) begin
            state_d = S_MOVE;
          end else if (req_back_c) begin
            dir_d   = ~dir_q;
            state_d = S_MOVE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    up_d        = (state_d == S_MOVE) && !dir_d;
    down_d      = (state_d == S_MOVE) && dir_d;
    door_d      = (state_d == S_DOOR);
    door_load_c = (state_d == S_DOOR) && (state_q != S_DOOR);
  end

  door_timer #(
    .CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (door_load_c),
    .dec_i    (state_q == S_DOOR),
    .expire_c (door_expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      dir_q         <= 1'b0;
      fault_q       <= 1'b0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      door_q        <= 1'b0;
      start_floor_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      dir_q         <= dir_d;
      fault_q       <= fault_d;
      up_q          <= up_d;
      down_q        <= down_d;
      door_q        <= door_d;
      start_floor_q <= start_floor_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign door_open = door_q;
  assign pending   = pending_q;
  assign dir       = dir_q;
  assign fault     = fault_q;

endmodule

// File: doc/elevator_sched.md
ELEVATOR_SCHED -- requirements
Module: elevator_sched

Interface
REQ-001 SHALL have parameter NFLOORS, default 4, number of floors served (floor index 0..NFLOORS-1).
REQ-002 SHALL have parameter DOOR_CYCLES, default 8, clock cycles door_open stays high per stop.
REQ-003 SHALL have parameter ARRIVE_TIMEOUT, default 4, max cycles in WAIT before fault.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 call  input  NFLOORS  level-sensitive floor request buttons, bit i = floor i.
REQ-007 floor  input  $clog2(NFLOORS)  current floor index from elevator FSM (0 = ground).
REQ-008 up  output  1  one-cycle move-up pulse to elevator FSM.
REQ-009 down  output  1  one-cycle move-down pulse to elevator FSM.
REQ-010 door_open  output  1  high while stopped with door open.
REQ-011 pending  output  NFLOORS  latched outstanding requests.
REQ-012 dir  output  1  travel direction, 0 = up, 1 = down.
REQ-013 fault  output  1  sticky arrival-timeout flag.

Function
REQ-014 pending SHALL update each cycle as pending | call, then clear bit floor when in DOOR state (clear wins over set for that bit).
REQ-015 States SHALL be IDLE, MOVE, WAIT, DOOR; register state is the only source of up/down/door_open (Moore outputs).
REQ-016 IDLE: if pending[floor] -> DOOR; else if request above and (dir=0 or none below) -> dir<=0, MOVE; else if request below -> dir<=1, MOVE; else stay IDLE.
REQ-017 MOVE: up=~dir, down=dir for exactly one cycle; latch floor into start_floor; next state WAIT unconditionally.
REQ-018 up and down SHALL never be high together and SHALL be 0 outside MOVE.
REQ-019 WAIT: when floor != start_floor -> if pending[floor] -> DOOR; else if request further in dir -> MOVE; else IDLE.
REQ-020 WAIT: if floor unchanged for ARRIVE_TIMEOUT cycles -> set fault, go IDLE; fault clears only on rst.
REQ-021 While fault=1, IDLE SHALL not enter MOVE; DOOR service at current floor still allowed.
REQ-022 DOOR: door_open=1; timer loads DOOR_CYCLES on entry, decrements each cycle; exit on expiry after exactly DOOR_CYCLES cycles of door_open.
REQ-023 DOOR exit: request further in dir -> MOVE; else request opposite -> flip dir, MOVE; else IDLE.
REQ-024 A call at the current floor during DOOR SHALL be absorbed (pending bit cleared) and SHALL NOT restart the timer.
REQ-025 Top floor SHALL never issue up, floor 0 SHALL never issue down (guaranteed by "request above/below" using pending only, plus explicit guard).
REQ-026 Latency: call at idle current floor -> door_open high 2 cycles after call first sampled high (1 to latch, 1 to enter DOOR).
REQ-027 Simultaneous calls above and below from IDLE with dir=0 SHALL go up; with dir=1 SHALL go down (SCAN).

Reset
REQ-028 On rst: state=IDLE, up=0, down=0, door_open=0, pending=0, dir=0, fault=0, timer=0, start_floor=0.
REQ-029 rst mid-operation (any state) SHALL abort immediately, drop all pending requests, and emit no further pulses until a new call.

Structure
REQ-030 sched_state_t enum and default NFLOORS constant SHALL live in the shared fsm_pkg.
REQ-031 Door countdown SHALL be a sub-module door_timer (load, dec, expire) instantiated once.
REQ-032 "Request above/below/further" SHALL be derived combinationally by masking pending with floor-relative thermometer masks.

Verification
REQ-033 Idle at floor 0, call=0001 one cycle -> door_open high cycles 2..9, pending clears, no up/down.
REQ-034 Floor 0, call=1000 -> up pulse, model advances, three up pulses total, door_open at floor 3, dir=0.
REQ-035 At floor 1 moving up toward 3, call=0001 mid-travel -> serve floor 3 first, then dir=1, down pulses to floor 0.
REQ-036 Floor 2 idle dir=0, call=1001 same cycle -> up first (floor 3), then down to 0.
REQ-037 Model holds floor after up pulse -> fault=1 after 4 WAIT cycles, state IDLE, no further pulses until rst.
REQ-038 rst asserted during DOOR with pending=0110 -> next cycle all outputs 0, pending=0000.
